// File: rtl/rr_mux4_stream.sv
// ---------------------------------------------------------------------------
// rr_mux4_stream
//
// Round-robin 4:1 stream multiplexer. Four valid/ready source channels are
// arbitrated round-robin starting from a priority pointer. The granted word
// and its channel index are captured into a one-entry output buffer, which a
// downstream consumer drains with out_valid/out_ready. Completed downstream
// transfers are counted in a wrapping 16-bit counter.
//
// Ports:
//   clk         rising-edge clock
//   reset       synchronous, active-high reset
//   in0..in3    channel data
//   valid[3:0]  per-channel request (bit i belongs to in<i>)
//   ready[3:0]  per-channel accept, at most one bit high (combinational)
//   sel[1:0]    current grant index; equals the pointer when nothing is valid
//   out         buffered output word
//   out_ch      channel index of the word in out
//   out_valid   out/out_ch hold a word not yet taken downstream
//   out_ready   downstream accept
//   xfer_count  number of completed out_valid && out_ready transfers (wraps)
// ---------------------------------------------------------------------------
module rr_mux4_stream #(
    parameter int width = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [width-1:0] in0,
    input  logic [width-1:0] in1,
    input  logic [width-1:0] in2,
    input  logic [width-1:0] in3,
    input  logic [3:0]       valid,
    output logic [3:0]       ready,
    output logic [1:0]       sel,
    output logic [width-1:0] out,
    output logic [1:0]       out_ch,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      xfer_count
);

    logic [width-1:0] out_q, out_d;
    logic [1:0]       out_ch_q, out_ch_d;
    logic             out_valid_q, out_valid_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [15:0]      xfer_q, xfer_d;

    logic             any_valid;
    logic             load_en;
    logic             accept;
    logic             drain;
    logic             found;
    logic [1:0]       idx;
    logic [1:0]       grant;
    logic [width-1:0] grant_data;

    assign any_valid = |valid;

    // The buffer can take a word when empty or when it is being drained in
    // this same cycle, which keeps one transfer per cycle under full load.
    assign load_en = !out_valid_q || out_ready;
    assign accept  = load_en && any_valid;
    assign drain   = out_valid_q && out_ready;

    // Round-robin search: the first valid channel at or after the pointer.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        grant = ptr_q;
        found = 1'b0;
        idx   = ptr_q;
        for (int k = 0; k < 4; k++) begin
            idx = ptr_q + 2'(k);
            if (!found && valid[idx]) begin
                grant = idx;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        grant_data = in0;
        case (grant)
            2'd0: grant_data = in0;
            2'd1: grant_data = in1;
            2'd2: grant_data = in2;
            2'd3: grant_data = in3;
            default: grant_data = in0;
        endcase
    end

    // Grant index falls back to the pointer when nothing requests.
    assign sel = grant;

    // Gate with reset so no source sees its word taken while state clears.
    assign ready = (accept && !reset) ? (4'b0001 << grant) : 4'b0000;

    always_comb begin
        out_d       = out_q;
        out_ch_d    = out_ch_q;
        out_valid_d = out_valid_q;
        ptr_d       = ptr_q;
        xfer_d      = xfer_q + 16'(drain);
        if (accept) begin
            out_d       = grant_data;
            out_ch_d    = grant;
            out_valid_d = 1'b1;
            ptr_d       = grant + 2'd1;
        end else if (load_en) begin
            // Buffer emptied (or already empty) with nothing to refill it;
            // the stale word stays visible but is no longer valid.
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples its next value from the same pre-edge snapshot.
        if (reset) begin
            out_q       <= '0;
            out_ch_q    <= 2'd0;
            out_valid_q <= 1'b0;
            ptr_q       <= 2'd0;
            xfer_q      <= 16'd0;
        end else begin
            out_q       <= out_d;
            out_ch_q    <= out_ch_d;
            out_valid_q <= out_valid_d;
            ptr_q       <= ptr_d;
            xfer_q      <= xfer_d;
        end
    end

    assign out        = out_q;
    assign out_ch     = out_ch_q;
    assign out_valid  = out_valid_q;
    assign xfer_count = xfer_q;

endmodule

// File: tb/tb_rr_mux4_stream.sv
// ---------------------------------------------------------------------------
// tb_rr_mux4_stream
//
// Directed bench for rr_mux4_stream. Channel data is fixed (FFFF, 0000,
// FE00, 01FF). Each table row sets valid/out_ready, checks the combinational
// ready/sel and the registered buffer state before the next rising edge,
// then clocks once. Reset-during-hold and counter wrap are hand sequences.
// ---------------------------------------------------------------------------
module tb_rr_mux4_stream;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] in0, in1, in2, in3;
    logic [3:0]  valid;
    logic [3:0]  ready;
    logic [1:0]  sel;
    logic [15:0] out;
    logic [1:0]  out_ch;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] xfer_count;

    int total  = 0;
    int passed = 0;

    rr_mux4_stream #(.width(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .in0        (in0),
        .in1        (in1),
        .in2        (in2),
        .in3        (in3),
        .valid      (valid),
        .ready      (ready),
        .sel        (sel),
        .out        (out),
        .out_ch     (out_ch),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .xfer_count (xfer_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  valid;
        logic        out_ready;
        logic [3:0]  exp_ready;
        logic [1:0]  exp_sel;
        logic        exp_ov;
        logic [15:0] exp_out;
        logic [1:0]  exp_ch;
        logic [15:0] exp_xfer;
    } vec_t;

    localparam int NVEC = 17;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Advance one rising edge; inputs change and outputs are sampled 1 time
    // unit after it, well away from the next edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // valid, out_ready | ready, sel, out_valid, out, out_ch, xfer_count
        // Full rotation with all channels requesting.
        vecs[0]  = '{4'hF, 1'b1, 4'b0001, 2'd0, 1'b0, 16'h0000, 2'd0, 16'd0};
        vecs[1]  = '{4'hF, 1'b1, 4'b0010, 2'd1, 1'b1, 16'hFFFF, 2'd0, 16'd0};
        vecs[2]  = '{4'hF, 1'b1, 4'b0100, 2'd2, 1'b1, 16'h0000, 2'd1, 16'd1};
        vecs[3]  = '{4'hF, 1'b1, 4'b1000, 2'd3, 1'b1, 16'hFE00, 2'd2, 16'd2};
        // Only channel 2 requests, twice; pointer moves to 3.
        vecs[4]  = '{4'h4, 1'b1, 4'b0100, 2'd2, 1'b1, 16'h01FF, 2'd3, 16'd3};
        vecs[5]  = '{4'h4, 1'b1, 4'b0100, 2'd2, 1'b1, 16'hFE00, 2'd2, 16'd4};
        // Channels 3 and 0: pointer at 3 so 3 goes first, then 0.
        vecs[6]  = '{4'h9, 1'b1, 4'b1000, 2'd3, 1'b1, 16'hFE00, 2'd2, 16'd5};
        vecs[7]  = '{4'h9, 1'b1, 4'b0001, 2'd0, 1'b1, 16'h01FF, 2'd3, 16'd6};
        // Backpressure for three edges while FFFF is buffered.
        vecs[8]  = '{4'hF, 1'b0, 4'b0000, 2'd1, 1'b1, 16'hFFFF, 2'd0, 16'd7};
        vecs[9]  = '{4'hF, 1'b0, 4'b0000, 2'd1, 1'b1, 16'hFFFF, 2'd0, 16'd7};
        vecs[10] = '{4'hF, 1'b0, 4'b0000, 2'd1, 1'b1, 16'hFFFF, 2'd0, 16'd7};
        // Release: drain FFFF and load 0000 from channel 1 on the same edge.
        vecs[11] = '{4'hF, 1'b1, 4'b0010, 2'd1, 1'b1, 16'hFFFF, 2'd0, 16'd7};
        // Idle: buffer drains, out keeps last word, sel shows pointer.
        vecs[12] = '{4'h0, 1'b1, 4'b0000, 2'd2, 1'b1, 16'h0000, 2'd1, 16'd8};
        vecs[13] = '{4'h0, 1'b1, 4'b0000, 2'd2, 1'b0, 16'h0000, 2'd1, 16'd9};
        vecs[14] = '{4'h0, 1'b0, 4'b0000, 2'd2, 1'b0, 16'h0000, 2'd1, 16'd9};
        // Empty buffer loads even with out_ready low.
        vecs[15] = '{4'h8, 1'b0, 4'b1000, 2'd3, 1'b0, 16'h0000, 2'd1, 16'd9};
        vecs[16] = '{4'h0, 1'b0, 4'b0000, 2'd0, 1'b1, 16'h01FF, 2'd3, 16'd9};

        in0 = 16'hFFFF;
        in1 = 16'h0000;
        in2 = 16'hFE00;
        in3 = 16'h01FF;

        // Reset with requests pending: nothing may be accepted.
        reset     = 1'b1;
        valid     = 4'hF;
        out_ready = 1'b1;
        step();
        check("ready_in_reset", 32'(ready), 32'h0);
        step();
        reset = 1'b0;
        check("rst_out", 32'(out), 32'h0);
        check("rst_out_ch", 32'(out_ch), 32'h0);
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_xfer", 32'(xfer_count), 32'h0);

        for (int i = 0; i < NVEC; i++) begin
            valid     = vecs[i].valid;
            out_ready = vecs[i].out_ready;
            #1;
            check($sformatf("v%0d_ready", i), 32'(ready), 32'(vecs[i].exp_ready));
            check($sformatf("v%0d_sel", i), 32'(sel), 32'(vecs[i].exp_sel));
            check($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].exp_ov));
            check($sformatf("v%0d_out", i), 32'(out), 32'(vecs[i].exp_out));
            check($sformatf("v%0d_out_ch", i), 32'(out_ch), 32'(vecs[i].exp_ch));
            check($sformatf("v%0d_xfer", i), 32'(xfer_count), 32'(vecs[i].exp_xfer));
            step();
        end

        // Reset while 01FF is held valid: the word is discarded, uncounted.
        valid     = 4'hF;
        out_ready = 1'b0;
        reset     = 1'b1;
        #1;
        check("midrst_ready", 32'(ready), 32'h0);
        step();
        check("midrst_ready2", 32'(ready), 32'h0);
        check("midrst_out", 32'(out), 32'h0);
        check("midrst_out_ch", 32'(out_ch), 32'h0);
        check("midrst_out_valid", 32'(out_valid), 32'h0);
        check("midrst_xfer", 32'(xfer_count), 32'h0);
        reset = 1'b0;
        valid = 4'h0;
        #1;
        check("midrst_ptr", 32'(sel), 32'h0);

        // Counter wrap: channel 0 streams continuously into a free sink.
        // First edge loads, every later edge drains one word.
        valid     = 4'h1;
        out_ready = 1'b1;
        repeat (65536) step();
        check("wrap_ffff", 32'(xfer_count), 32'hFFFF);
        check("wrap_ov", 32'(out_valid), 32'h1);
        step();
        check("wrap_zero", 32'(xfer_count), 32'h0000);
        check("wrap_out", 32'(out), 32'hFFFF);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
